// File: rtl/rambus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rambus_arbiter_pkg
// Description : Shared widths and FSM state encoding for the rambus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rambus_arbiter_pkg;

    localparam int RAMBUS_AW = 10;
    localparam int RAMBUS_DW = 32;
    localparam int WD_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rambus_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : rambus_arbiter_watchdog
// Description : 8-bit cycle counter flagging a RAM cycle that never acks.
// Revision    : 1.0 - initial release
// ============================================================================
module rambus_arbiter_watchdog
    import rambus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [WD_W-1:0] c_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Count holds the number of completed BUS cycles minus one at each edge.
    assign timeout = enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/rambus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rambus_arbiter
// Description : Round-robin two-master Wishbone arbiter for the shared RAM bus.
// Revision    : 1.0 - initial release
// ============================================================================
module rambus_arbiter
    import rambus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 m0_cyc,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    input  logic [3:0]           m0_sel,
    input  logic [RAMBUS_AW-1:0] m0_adr,
    input  logic [RAMBUS_DW-1:0] m0_dat_i,
    output logic                 m0_ack,
    output logic                 m0_err,
    output logic [RAMBUS_DW-1:0] m0_dat_o,
    input  logic                 m1_cyc,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    input  logic [3:0]           m1_sel,
    input  logic [RAMBUS_AW-1:0] m1_adr,
    input  logic [RAMBUS_DW-1:0] m1_dat_i,
    output logic                 m1_ack,
    output logic                 m1_err,
    output logic [RAMBUS_DW-1:0] m1_dat_o,
    output logic                 rambus_wb_clk_o,
    output logic                 rambus_wb_rst_o,
    output logic                 rambus_wb_cyc_o,
    output logic                 rambus_wb_stb_o,
    output logic                 rambus_wb_we_o,
    output logic [3:0]           rambus_wb_sel_o,
    output logic [RAMBUS_AW-1:0] rambus_wb_adr_o,
    output logic [RAMBUS_DW-1:0] rambus_wb_dat_o,
    input  logic                 rambus_wb_ack_i,
    input  logic [RAMBUS_DW-1:0] rambus_wb_dat_i
);

    state_t r_state;
    logic   r_last;
    logic   r_grant;
    logic   w_req0;
    logic   w_req1;
    logic   w_gnt;
    logic   w_abort;
    logic   w_timeout;
    logic   w_in_bus;

    assign rambus_wb_clk_o = clock;
    assign rambus_wb_rst_o = reset;

    assign w_req0   = m0_cyc & m0_stb;
    assign w_req1   = m1_cyc & m1_stb;
    // On contention the master that was not served last wins.
    assign w_gnt    = (w_req0 & w_req1) ? ~r_last : w_req1;
    assign w_abort  = r_grant ? ~m1_cyc : ~m0_cyc;
    assign w_in_bus = (r_state == ST_BUS);

    rambus_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (~w_in_bus),
        .enable  (w_in_bus),
        .timeout (w_timeout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_last          <= 1'b1;
            r_grant         <= 1'b0;
            m0_ack          <= 1'b0;
            m0_err          <= 1'b0;
            m0_dat_o        <= '0;
            m1_ack          <= 1'b0;
            m1_err          <= 1'b0;
            m1_dat_o        <= '0;
            rambus_wb_cyc_o <= 1'b0;
            rambus_wb_stb_o <= 1'b0;
            rambus_wb_we_o  <= 1'b0;
            rambus_wb_sel_o <= '0;
            rambus_wb_adr_o <= '0;
            rambus_wb_dat_o <= '0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_grant         <= w_gnt;
                        r_last          <= w_gnt;
                        rambus_wb_we_o  <= w_gnt ? m1_we    : m0_we;
                        rambus_wb_sel_o <= w_gnt ? m1_sel   : m0_sel;
                        rambus_wb_adr_o <= w_gnt ? m1_adr   : m0_adr;
                        rambus_wb_dat_o <= w_gnt ? m1_dat_i : m0_dat_i;
                        rambus_wb_cyc_o <= 1'b1;
                        rambus_wb_stb_o <= 1'b1;
                        r_state         <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (rambus_wb_ack_i) begin
                        if (r_grant) begin
                            m1_ack   <= 1'b1;
                            m1_dat_o <= rambus_wb_dat_i;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_dat_o <= rambus_wb_dat_i;
                        end
                        rambus_wb_cyc_o <= 1'b0;
                        rambus_wb_stb_o <= 1'b0;
                        r_state         <= ST_DONE;
                    end else if (w_abort) begin
                        rambus_wb_cyc_o <= 1'b0;
                        rambus_wb_stb_o <= 1'b0;
                        r_state         <= ST_DONE;
                    end else if (w_timeout) begin
                        if (r_grant) begin
                            m1_err <= 1'b1;
                        end else begin
                            m0_err <= 1'b1;
                        end
                        rambus_wb_cyc_o <= 1'b0;
                        rambus_wb_stb_o <= 1'b0;
                        r_state         <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rambus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rambus_arbiter
// Description : Scoreboard bench for rambus_arbiter with directed transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rambus_arbiter;

    localparam int TMO = 4;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [9:0]  adr;
        logic [31:0] dat;
    } bus_t;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          len;
    } rsp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [3:0]  m0_sel = 0;
    logic [9:0]  m0_adr = 0;
    logic [31:0] m0_dat_i = 0;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [3:0]  m1_sel = 0;
    logic [9:0]  m1_adr = 0;
    logic [31:0] m1_dat_i = 0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        rambus_wb_clk_o, rambus_wb_rst_o;
    logic        rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o;
    logic [3:0]  rambus_wb_sel_o;
    logic [9:0]  rambus_wb_adr_o;
    logic [31:0] rambus_wb_dat_o;
    logic        rambus_wb_ack_i;
    logic [31:0] ram_rdata = 32'hDEADBEEF;
    logic        ram_ack = 0, force_ack = 0, ram_en = 1, scramble = 0, tight = 0;
    int          ram_cnt = 0;
    int          ram_delay = 2;

    // Stimulus owns the write pointers, masters/monitor own the read pointers.
    bus_t mreq0[32], mreq1[32], expb[32];
    rsp_t exp0[32], exp1[32];
    int   mw0 = 0, mw1 = 0, mr0 = 0, mr1 = 0;
    int   ebw = 0, ebr = 0, e0w = 0, e0r = 0, e1w = 0, e1r = 0;
    logic act0 = 0, act1 = 0;

    int   n_pass = 0, n_total = 0;

    always #5 clock = ~clock;

    assign rambus_wb_ack_i = ram_ack | force_ack;

    rambus_arbiter #(
        .TIMEOUT (TMO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .m0_cyc          (m0_cyc),
        .m0_stb          (m0_stb),
        .m0_we           (m0_we),
        .m0_sel          (m0_sel),
        .m0_adr          (m0_adr),
        .m0_dat_i        (m0_dat_i),
        .m0_ack          (m0_ack),
        .m0_err          (m0_err),
        .m0_dat_o        (m0_dat_o),
        .m1_cyc          (m1_cyc),
        .m1_stb          (m1_stb),
        .m1_we           (m1_we),
        .m1_sel          (m1_sel),
        .m1_adr          (m1_adr),
        .m1_dat_i        (m1_dat_i),
        .m1_ack          (m1_ack),
        .m1_err          (m1_err),
        .m1_dat_o        (m1_dat_o),
        .rambus_wb_clk_o (rambus_wb_clk_o),
        .rambus_wb_rst_o (rambus_wb_rst_o),
        .rambus_wb_cyc_o (rambus_wb_cyc_o),
        .rambus_wb_stb_o (rambus_wb_stb_o),
        .rambus_wb_we_o  (rambus_wb_we_o),
        .rambus_wb_sel_o (rambus_wb_sel_o),
        .rambus_wb_adr_o (rambus_wb_adr_o),
        .rambus_wb_dat_o (rambus_wb_dat_o),
        .rambus_wb_ack_i (rambus_wb_ack_i),
        .rambus_wb_dat_i (ram_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    // RAM: acks ram_delay cycles after it first sees cyc/stb.
    always @(posedge clock) begin
        #1;
        if (rambus_wb_cyc_o && rambus_wb_stb_o && ram_en && !ram_ack) begin
            if (ram_cnt == ram_delay) begin
                ram_ack   = 1'b1;
                ram_rdata = (rambus_wb_adr_o == 10'h005) ? 32'h12345678
                                                         : (32'hD000_0000 | 32'(rambus_wb_adr_o));
                ram_cnt   = 0;
            end else begin
                ram_cnt++;
            end
        end else begin
            ram_ack = 1'b0;
            ram_cnt = 0;
        end
    end

    always @(posedge clock) begin
        #1;
        if (reset) begin
            m0_cyc = 0; m0_stb = 0; act0 = 0; mr0 = mw0;
        end else begin
            if (act0 && (m0_ack || m0_err)) begin
                m0_cyc = 0; m0_stb = 0; act0 = 0;
            end
            if (!act0 && mr0 != mw0) begin
                m0_we = mreq0[mr0].we; m0_sel = mreq0[mr0].sel;
                m0_adr = mreq0[mr0].adr; m0_dat_i = mreq0[mr0].dat;
                m0_cyc = 1; m0_stb = 1; act0 = 1; mr0++;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (reset) begin
            m1_cyc = 0; m1_stb = 0; act1 = 0; mr1 = mw1;
        end else begin
            if (act1 && (m1_ack || m1_err)) begin
                m1_cyc = 0; m1_stb = 0; act1 = 0;
            end
            if (!act1 && mr1 != mw1) begin
                m1_we = mreq1[mr1].we; m1_sel = mreq1[mr1].sel;
                m1_adr = mreq1[mr1].adr; m1_dat_i = mreq1[mr1].dat;
                m1_cyc = 1; m1_stb = 1; act1 = 1; mr1++;
            end else if (act1 && scramble && rambus_wb_cyc_o) begin
                m1_we = ~m1_we; m1_sel = ~m1_sel; m1_adr = ~m1_adr; m1_dat_i = ~m1_dat_i;
            end
        end
    end

    // Monitor: bus cycles against expb, master responses against exp0/exp1.
    logic prev_cyc = 0;
    int   gap = 100, blen = 0, last_len = 0;
    bus_t cur;
    always @(negedge clock) begin
        rsp_t e;
        if (rambus_wb_cyc_o) begin
            if (!prev_cyc) begin
                if (tight) chk("bus_gap_exact", 64'(gap), 64'd2);
                else       chk("bus_gap_min", 64'(gap >= 2), 64'd1);
                if (ebr == ebw) begin
                    chk("bus_unexpected", 64'(rambus_wb_adr_o), 64'h3FFFF);
                end else begin
                    cur = expb[ebr];
                    ebr++;
                end
                blen = 0;
            end
            blen++;
            chk("bus_fields", {rambus_wb_stb_o, rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_adr_o, rambus_wb_dat_o},
                {1'b1, cur.we, cur.sel, cur.adr, cur.dat});
        end else begin
            if (prev_cyc) last_len = blen;
            gap = prev_cyc ? 1 : gap + 1;
        end
        prev_cyc = rambus_wb_cyc_o;
        if (m0_ack || m0_err) begin
            if (e0r == e0w) begin
                chk("m0_unexpected", {m0_ack, m0_err}, 0);
            end else begin
                e = exp0[e0r];
                e0r++;
                chk("m0_rsp", {m0_ack, m0_err, m0_dat_o}, {~e.err, e.err, e.dat});
                chk("m0_len", 64'(last_len), 64'(e.len));
                chk("m0_cyc_drop", rambus_wb_cyc_o, 0);
            end
        end
        if (m1_ack || m1_err) begin
            if (e1r == e1w) begin
                chk("m1_unexpected", {m1_ack, m1_err}, 0);
            end else begin
                e = exp1[e1r];
                e1r++;
                chk("m1_rsp", {m1_ack, m1_err, m1_dat_o}, {~e.err, e.err, e.dat});
                chk("m1_len", 64'(last_len), 64'(e.len));
                chk("m1_cyc_drop", rambus_wb_cyc_o, 0);
            end
        end
    end

    task automatic req(input int m, input logic we, input logic [3:0] sel,
                       input logic [9:0] adr, input logic [31:0] dat);
        if (m == 0) begin mreq0[mw0] = '{we, sel, adr, dat}; mw0++; end
        else        begin mreq1[mw1] = '{we, sel, adr, dat}; mw1++; end
    endtask

    task automatic ebus(input logic we, input logic [3:0] sel, input logic [9:0] adr, input logic [31:0] dat);
        expb[ebw] = '{we, sel, adr, dat};
        ebw++;
    endtask

    task automatic ersp(input int m, input logic err, input logic [31:0] dat, input int len);
        if (m == 0) begin exp0[e0w] = '{err, dat, len}; e0w++; end
        else        begin exp1[e1w] = '{err, dat, len}; e1w++; end
    endtask

    task automatic wait_cyc(input logic level, input string name);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #3;
            if (rambus_wb_cyc_o == level) begin ok = 1; break; end
        end
        if (!ok) chk(name, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock); #3;
            if (mr0 == mw0 && mr1 == mw1 && !act0 && !act1 && e0r == e0w && e1r == e1w
                && ebr == ebw && !rambus_wb_cyc_o) begin
                ok = 1; break;
            end
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #3;
        chk("rst_m0", {m0_ack, m0_err, m0_dat_o}, 0);
        chk("rst_m1", {m1_ack, m1_err, m1_dat_o}, 0);
        chk("rst_bus_ctl", {rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o, rambus_wb_sel_o}, 0);
        chk("rst_bus_data", {rambus_wb_adr_o, rambus_wb_dat_o}, 0);
        reset = 0;

        // Simultaneous persistent requests: m0 first, then strict alternation.
        @(posedge clock); #3;
        for (int i = 0; i < 4; i++) begin
            req(0, 0, 4'hF, 10'h010 + 10'(i), 32'h0);
            req(1, 0, 4'hF, 10'h020 + 10'(i), 32'h0);
            ebus(0, 4'hF, 10'h010 + 10'(i), 32'h0);
            ebus(0, 4'hF, 10'h020 + 10'(i), 32'h0);
            ersp(0, 0, 32'hD000_0010 + 32'(i), 3);
            ersp(1, 0, 32'hD000_0020 + 32'(i), 3);
        end
        wait_cyc(1, "alt_first_start");
        wait_cyc(0, "alt_first_end");
        tight = 1;
        wait_idle("alt_drain");
        tight = 0;

        // Single read with a two-cycle RAM latency.
        req(0, 0, 4'hF, 10'h005, 32'h0);
        ebus(0, 4'hF, 10'h005, 32'h0);
        ersp(0, 0, 32'h12345678, 3);
        wait_idle("read_drain");

        // Write from m1 while it scrambles its inputs during the cycle.
        scramble = 1;
        req(1, 1, 4'b0011, 10'h3FF, 32'hCAFEF00D);
        ebus(1, 4'b0011, 10'h3FF, 32'hCAFEF00D);
        ersp(1, 0, 32'hD000_03FF, 3);
        wait_idle("write_drain");
        scramble = 0;

        // Timeout: err after TMO BUS cycles, read data left unchanged.
        ram_en = 0;
        req(0, 0, 4'hF, 10'h0AA, 32'h0);
        ebus(0, 4'hF, 10'h0AA, 32'h0);
        ersp(0, 1, 32'h12345678, TMO);
        wait_idle("timeout_drain");
        force_ack = 1;
        repeat (2) begin
            @(negedge clock);
            chk("late_ack_ignored", {m0_ack, m0_err, m1_ack, m1_err, rambus_wb_cyc_o}, 0);
        end
        @(posedge clock); #1;
        force_ack = 0;

        // Reset during BUS drops the cycle, then m0 wins again.
        req(0, 0, 4'hF, 10'h055, 32'h0);
        ebus(0, 4'hF, 10'h055, 32'h0);
        wait_cyc(1, "rstmid_start");
        @(posedge clock); #2;
        reset = 1;
        #1;
        chk("rstmid_bus_low", {rambus_wb_cyc_o, rambus_wb_stb_o}, 0);
        chk("rstmid_no_rsp", {m0_ack, m0_err, m1_ack, m1_err}, 0);
        repeat (2) @(posedge clock);
        #3;
        reset = 0;
        ram_en = 1;
        req(0, 0, 4'hF, 10'h061, 32'h0);
        req(1, 0, 4'hF, 10'h062, 32'h0);
        ebus(0, 4'hF, 10'h061, 32'h0);
        ebus(0, 4'hF, 10'h062, 32'h0);
        ersp(0, 0, 32'hD000_0061, 3);
        ersp(1, 0, 32'hD000_0062, 3);
        wait_idle("post_reset_drain");

        repeat (3) @(posedge clock);
        #3;
        chk("final_queues", {32'(ebw - ebr), 32'((e0w - e0r) + (e1w - e1r))}, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
